// File: rtl/amba3_apb_if.sv
// amba3_apb_if: APB (AMBA3) bus bundle between one requester and one completer.
// Params : ADDR_BITS (paddr width), DATA_BITS (pwdata/prdata width)
// Signals: psel, penable, pwrite, paddr, pwdata  (requester -> completer)
//          prdata, pready, pslverr               (completer -> requester)
// Clock and reset are carried as plain ports on the attached modules.
interface amba3_apb_if #(
  parameter int ADDR_BITS = 32,
  parameter int DATA_BITS = 32
);
  logic                 psel;
  logic                 penable;
  logic                 pwrite;
  logic [ADDR_BITS-1:0] paddr;
  logic [DATA_BITS-1:0] pwdata;
  logic [DATA_BITS-1:0] prdata;
  logic                 pready;
  logic                 pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/amba3_apb_slave_mem.sv
// amba3_apb_slave_mem: APB (AMBA3) completer backed by a word-addressed RAM,
// with a fixed number of wait states per access phase.
// Ports : pclk    bus clock, all state changes on its rising edge
//         preset  synchronous active-high reset (clears FSM, counter, memory)
//         bus     amba3_apb_if.slave (psel/penable/pwrite/paddr/pwdata in,
//                 prdata/pready/pslverr out)
// Params: ADDR_BITS, DATA_BITS (8/16/32/64), MEM_DEPTH (power of 2),
//         WAIT_STATES (0..15)
// Macro : APB_SLVERR_EN -- when defined, out-of-window or unaligned
//         addresses complete with pslverr=1, no write and prdata=0. When
//         undefined, pslverr is 0, high address bits alias and the low
//         byte-offset bits are ignored.
module amba3_apb_slave_mem #(
  parameter int ADDR_BITS   = 32,
  parameter int DATA_BITS   = 32,
  parameter int MEM_DEPTH   = 1024,
  parameter int WAIT_STATES = 0
) (
  input logic         pclk,
  input logic         preset,
  amba3_apb_if.slave  bus
);

  localparam int DATA_BASE = $clog2(DATA_BITS / 8);
  localparam int IDX_BITS  = $clog2(MEM_DEPTH);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t               state_q, state, state_d;
  logic [3:0]           wcnt_q, wcnt_d;
  logic [DATA_BITS-1:0] mem [MEM_DEPTH];
  logic [IDX_BITS-1:0]  idx;
  logic                 done;
  logic                 addr_err;
  logic                 wr_en;

  assign idx = bus.paddr[DATA_BASE +: IDX_BITS];

`ifdef APB_SLVERR_EN
  localparam logic [ADDR_BITS-1:0] LOW_MASK =
    ADDR_BITS'((64'd1 << DATA_BASE) - 64'd1);
  // Anything outside the window, or not word aligned, is an error.
  assign addr_err = ((bus.paddr >> (DATA_BASE + IDX_BITS)) != '0) ||
                    ((bus.paddr & LOW_MASK) != '0);
`else
  logic unused_paddr;
  assign unused_paddr = ^bus.paddr;
  assign addr_err     = 1'b0;
`endif

  // APB gives no advance notice of a setup phase, so a registered IDLE that
  // sees psel && !penable is already the SETUP cycle of the transfer. This
  // keeps the access phase (and therefore pready/commit) aligned with the bus.
  always_comb begin
    state = state_q;
    if (state_q == IDLE && bus.psel && !bus.penable) state = SETUP;
  end

  assign bus.pready = !(state == ACCESS && wcnt_q != 4'd0);
  assign done       = (state == ACCESS) && bus.pready;

  always_comb begin
    state_d = state;
    wcnt_d  = wcnt_q;
    case (state)
      IDLE:  state_d = IDLE;
      SETUP: begin
        state_d = ACCESS;
        wcnt_d  = 4'(WAIT_STATES);
      end
      ACCESS: begin
        if (!bus.psel) begin
          // Requester abandoned the transfer: drop it without committing.
          state_d = IDLE;
          wcnt_d  = 4'd0;
        end else if (!bus.pready) begin
          wcnt_d = wcnt_q - 4'd1;
        end else begin
          state_d = (bus.psel && !bus.penable) ? SETUP : IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        wcnt_d  = 4'd0;
      end
    endcase
  end

  always_ff @(posedge pclk) begin
    if (preset) begin
      state_q <= IDLE;
      wcnt_q  <= 4'd0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
    end
  end

  assign wr_en = done && bus.psel && bus.penable && bus.pwrite && !addr_err;

  // Reset wins over a commit in the same cycle, so an interrupted write is lost.
  always_ff @(posedge pclk) begin
    if (preset) begin
      for (int i = 0; i < MEM_DEPTH; i++) mem[i] <= '0;
    end else if (wr_en) begin
      mem[idx] <= bus.pwdata;
    end
  end

  assign bus.prdata  = (done && !bus.pwrite && !addr_err) ? mem[idx] : '0;
  assign bus.pslverr = done && addr_err;

endmodule

// File: tb/tb_amba3_apb_slave_mem.sv
module tb_amba3_apb_slave_mem;

  logic        pclk = 1'b0;
  logic        preset;
  logic        psel, penable, pwrite;
  logic [31:0] paddr, pwdata;
  int          sel;   // 0 -> zero-wait DUT, 1 -> three-wait DUT

  int n_tests = 0;
  int n_fail  = 0;

  bit [31:0] model [int];   // key: sel*4096 + word index

  always #5 pclk = ~pclk;

  amba3_apb_if #(.ADDR_BITS(32), .DATA_BITS(32)) bus0 ();
  amba3_apb_if #(.ADDR_BITS(32), .DATA_BITS(32)) bus3 ();

  assign bus0.psel    = psel && (sel == 0);
  assign bus0.penable = penable;
  assign bus0.pwrite  = pwrite;
  assign bus0.paddr   = paddr;
  assign bus0.pwdata  = pwdata;
  assign bus3.psel    = psel && (sel == 1);
  assign bus3.penable = penable;
  assign bus3.pwrite  = pwrite;
  assign bus3.paddr   = paddr;
  assign bus3.pwdata  = pwdata;

  wire        pready_s  = (sel == 1) ? bus3.pready  : bus0.pready;
  wire [31:0] prdata_s  = (sel == 1) ? bus3.prdata  : bus0.prdata;
  wire        pslverr_s = (sel == 1) ? bus3.pslverr : bus0.pslverr;

  amba3_apb_slave_mem #(.ADDR_BITS(32), .DATA_BITS(32), .MEM_DEPTH(1024),
                        .WAIT_STATES(0))
    dut0 (.pclk(pclk), .preset(preset), .bus(bus0));

  amba3_apb_slave_mem #(.ADDR_BITS(32), .DATA_BITS(32), .MEM_DEPTH(1024),
                        .WAIT_STATES(3))
    dut3 (.pclk(pclk), .preset(preset), .bus(bus3));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit addr_bad(input bit [31:0] a);
`ifdef APB_SLVERR_EN
    return (a >= 32'h1000) || (a % 4 != 0);
`else
    return 1'b0;
`endif
  endfunction

  function automatic int key(input bit [31:0] a);
    return sel * 4096 + int'((a / 4) % 1024);
  endfunction

  function automatic bit [31:0] model_rd(input bit [31:0] a);
    int k = key(a);
    return model.exists(k) ? model[k] : 32'h0;
  endfunction

  task automatic idle(input int n);
    psel = 1'b0; penable = 1'b0;
    repeat (n) begin @(posedge pclk); #1; end
  endtask

  // One APB transfer; checks pslverr and read data against the model.
  task automatic xfer(input bit w, input bit [31:0] a, input bit [31:0] d,
                      output bit [31:0] rd, output int cyc, output int lows);
    bit err_exp;
    bit [31:0] rd_exp;
    psel = 1'b1; penable = 1'b0; pwrite = w; paddr = a; pwdata = d;
    cyc = 1; lows = 0;
    @(posedge pclk); #1;
    penable = 1'b1; cyc = 2;
    while (!pready_s && lows < 40) begin
      lows++;
      @(posedge pclk); #1;
      cyc++;
    end
    chk("pready_done", pready_s, 1'b1);
    err_exp = addr_bad(a);
    rd_exp  = (w || err_exp) ? 32'h0 : model_rd(a);
    rd      = prdata_s;
    chk($sformatf("pslverr@%h", a), pslverr_s, err_exp);
    if (!w) chk($sformatf("rdata@%h", a), rd, rd_exp);
    if (w && !err_exp) model[key(a)] = d;
    @(posedge pclk); #1;
  endtask

  bit [31:0] wa [4] = '{32'h800, 32'h040, 32'h084, 32'h140};
  bit [31:0] wd [4] = '{32'h00040000, 32'h80003333, 32'h04400011, 32'h0000001C};
  bit [31:0] ra [4] = '{32'h040, 32'h140, 32'h800, 32'h084};

  initial begin
    bit [31:0] rd;
    int cyc, lows;
    int keys [$];
    bit [31:0] old40;

    sel = 0; psel = 0; penable = 0; pwrite = 0; paddr = 0; pwdata = 0;
    preset = 1'b1;
    repeat (3) begin @(posedge pclk); #1; end
    for (int s = 0; s < 2; s++) begin
      sel = s; #1;
      chk("rst_pready", pready_s, 1'b1);
      chk("rst_prdata", prdata_s, 32'h0);
      chk("rst_pslverr", pslverr_s, 1'b0);
    end
    preset = 1'b0;
    sel = 0;
    idle(2);

    // Wait states on the three-wait instance.
    sel = 1;
    for (int i = 0; i < 4; i++) begin
      xfer(1'b1, wa[i], wd[i], rd, cyc, lows);
      chk("ws_wr_cycles", cyc, 5);
      chk("ws_wr_lows", lows, 3);
    end
    for (int i = 0; i < 4; i++) begin
      xfer(1'b0, ra[i], 32'h0, rd, cyc, lows);
      chk("ws_rd_cycles", cyc, 5);
      chk("ws_rd_lows", lows, 3);
    end
    idle(2);

    // Basic read-back, zero waits.
    sel = 0;
    for (int i = 0; i < 4; i++) begin
      xfer(1'b1, wa[i], wd[i], rd, cyc, lows);
      chk("wr_cycles", cyc, 2);
      idle(1);
    end
    for (int i = 0; i < 4; i++) begin
      xfer(1'b0, ra[i], 32'h0, rd, cyc, lows);
      chk("rd_cycles", cyc, 2);
      idle(1);
    end
    xfer(1'b0, 32'h084, 32'h0, rd, cyc, lows);
    chk("basic_084", rd, 32'h04400011);
    idle(1);

    // Back-to-back overwrites and reads, no idle cycles in between.
    xfer(1'b1, 32'h040, 32'h12345678, rd, cyc, lows); chk("b2b_cyc", cyc, 2);
    xfer(1'b1, 32'h084, 32'h40506070, rd, cyc, lows); chk("b2b_cyc", cyc, 2);
    xfer(1'b1, 32'h018, 32'h22446688, rd, cyc, lows); chk("b2b_cyc", cyc, 2);
    xfer(1'b0, 32'h018, 32'h0, rd, cyc, lows); chk("b2b_018", rd, 32'h22446688);
    xfer(1'b0, 32'h040, 32'h0, rd, cyc, lows); chk("b2b_040", rd, 32'h12345678);
    xfer(1'b0, 32'h084, 32'h0, rd, cyc, lows); chk("b2b_084", rd, 32'h40506070);
    idle(2);

    // Reset during the access phase of a write.
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h040; pwdata = 32'hDEADBEEF;
    @(posedge pclk); #1;
    penable = 1'b1;
    preset  = 1'b1;
    @(posedge pclk); #1;
    chk("midrst_pready", pready_s, 1'b1);
    chk("midrst_prdata", prdata_s, 32'h0);
    chk("midrst_pslverr", pslverr_s, 1'b0);
    preset = 1'b0; psel = 1'b0; penable = 1'b0;
    model.delete();
    idle(1);
    xfer(1'b0, 32'h040, 32'h0, rd, cyc, lows);
    chk("midrst_rd040", rd, 32'h0);
    idle(1);

    // Aliasing / error response.
    xfer(1'b1, 32'h040, 32'h11112222, rd, cyc, lows);
    old40 = model_rd(32'h040);
    idle(1);
    xfer(1'b1, 32'h1040, 32'hA5A5A5A5, rd, cyc, lows);
    idle(1);
    xfer(1'b0, 32'h040, 32'h0, rd, cyc, lows);
`ifdef APB_SLVERR_EN
    chk("alias_rd040", rd, old40);
    xfer(1'b0, 32'h042, 32'h0, rd, cyc, lows);   // unaligned read: error, no data
`else
    chk("alias_rd040", rd, 32'hA5A5A5A5);
    chk("alias_old40", old40, 32'h11112222);
`endif
    idle(1);

    // Random soak against a last-write-wins model.
    for (int i = 0; i < 1000; i++) begin
      bit [31:0] a;
      a = 32'($urandom_range(0, 1023)) * 4;
      if (!model.exists(key(a))) keys.push_back(int'(a));
      xfer(1'b1, a, $urandom, rd, cyc, lows);
      idle($urandom_range(0, 10));
    end
    for (int i = keys.size() - 1; i > 0; i--) begin
      int j = int'($urandom_range(0, i));
      int t = keys[i];
      keys[i] = keys[j];
      keys[j] = t;
    end
    foreach (keys[i]) begin
      xfer(1'b0, 32'(keys[i]), 32'h0, rd, cyc, lows);
      idle($urandom_range(0, 2));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
